// File: rtl/axis_mem_stream_driver.sv
// Memory-backed multi-channel AXI-stream source plus a throttled result sink.
// Replays per-channel memories under a valid-throttle window and relaunches on the sink's tlast.
module axis_mem_stream_driver #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 12,
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int PERIOD_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       auto_restart,
    input  logic [NUM_CH*CNT_W-1:0]    cfg_len,
    input  logic [PERIOD_W-1:0]        cfg_period,
    input  logic [PERIOD_W-1:0]        cfg_on,
    input  logic                       cfg_ready_stall,
    input  logic [NUM_CH-1:0]          mem_we,
    input  logic [ADDR_W-1:0]          mem_waddr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic [NUM_CH-1:0]          m_tvalid,
    input  logic [NUM_CH-1:0]          m_tready,
    output logic [NUM_CH*DATA_W-1:0]   m_tdata,
    output logic [NUM_CH-1:0]          m_tlast,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [NUM_CH*CNT_W-1:0]    in_beat_cnt,
    output logic [CNT_W-1:0]           out_beat_cnt,
    output logic [15:0]                run_cnt,
    output logic                       busy,
    output logic                       done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RUN, RESTART} state_t;

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] phase;
    logic                window;
    logic                s_hs;
    logic                s_last_hs;
    logic                clear;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (cfg_period == '0 || phase >= cfg_period - PERIOD_W'(1))
            phase <= '0;
        else
            phase <= phase + PERIOD_W'(1);
    end

    // A window wider than the period (or no period at all) means no throttling.
    assign window = (cfg_period == '0) || (cfg_on >= cfg_period) || (phase < cfg_on);

    assign s_tready  = (state == RUN) && (!cfg_ready_stall || window);
    assign s_hs      = s_tvalid && s_tready;
    assign s_last_hs = s_hs && s_tlast;
    assign clear     = ((state == IDLE) && start) || (state == RESTART);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (start)
                    state_nxt = RESTART;
                else if (s_last_hs)
                    state_nxt = auto_restart ? RESTART : IDLE;
            end
            RESTART: state_nxt = start ? RESTART : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Every relaunch (automatic or start-forced) counts as a completed run.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt      <= '0;
            out_beat_cnt <= '0;
            done         <= 1'b0;
        end else begin
            done <= s_last_hs;
            if (state_nxt == RESTART)
                run_cnt <= run_cnt + 16'd1;
            if (clear)
                out_beat_cnt <= '0;
            else if (s_hs)
                out_beat_cnt <= sat_inc(out_beat_cnt);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] rd_addr;
        logic [CNT_W-1:0]  beat_cnt;
        logic [CNT_W-1:0]  len;
        logic              vld;
        logic              chan_done;
        logic              hs;
        logic              last;
        logic              done_nxt;

        assign len      = cfg_len[c*CNT_W +: CNT_W];
        assign last     = vld && (beat_cnt == len - CNT_W'(1));
        assign hs       = vld && m_tready[c];
        assign done_nxt = chan_done || (hs && last);

        always_ff @(posedge clk) begin
            if (mem_we[c])
                mem[mem_waddr] <= mem_wdata;
        end

        // Valid holds through a closed window until accepted; leaving RUN drops it unconditionally.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                vld       <= 1'b0;
                rd_addr   <= '0;
                beat_cnt  <= '0;
                chan_done <= 1'b0;
            end else if (state == RUN) begin
                if (hs) begin
                    rd_addr  <= rd_addr + ADDR_W'(1);
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
                chan_done <= done_nxt;
                if (state_nxt != RUN)
                    vld <= 1'b0;
                else if (vld && !hs)
                    vld <= 1'b1;
                else
                    vld <= window && !done_nxt && (len != '0);
            end else begin
                vld <= 1'b0;
            end
        end

        assign m_tvalid[c]                   = vld;
        assign m_tlast[c]                    = last;
        assign m_tdata[c*DATA_W +: DATA_W]   = vld ? mem[rd_addr] : '0;
        assign in_beat_cnt[c*CNT_W +: CNT_W] = beat_cnt;
    end

endmodule

// File: doc/axis_mem_stream_driver.md
Name: axis_mem_stream_driver

Overview:
Parametrised, multi-channel, memory-backed AXI-stream stimulus and sink block for system-level simulation of the SA3D accelerator top. It replays per-channel preloaded memories into NUM_CH independent master streams under a programmable valid-throttle pattern. It accepts the DUT's result stream with optional ready throttling and counts beats. On the DUT's final beat (tlast) it either re-launches the whole run automatically or returns to idle.

Parameters:
DATA_W, 64, data width of every stream and memory word
ADDR_W, 12, memory address width; DEPTH = 2**ADDR_W words per channel
NUM_CH, 2, number of independent master (source) channels
CNT_W, 32, width of beat-length config and beat counters
PERIOD_W, 10, width of throttle period/on-window config

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle launch/relaunch pulse
auto_restart  in  1  relaunch a run after each accepted s_tlast
cfg_len  in  NUM_CH*CNT_W  beats per run, per channel (ch0 in LSBs)
cfg_period  in  PERIOD_W  throttle period in cycles; 0 = no throttle
cfg_on  in  PERIOD_W  window-open cycles per period
cfg_ready_stall  in  1  1 = s_tready follows throttle window; 0 = s_tready constant 1
mem_we  in  NUM_CH  per-channel memory write enable
mem_waddr  in  ADDR_W  shared memory write address
mem_wdata  in  DATA_W  shared memory write data
m_tvalid  out  NUM_CH  source valid, per channel
m_tready  in  NUM_CH  source ready, per channel
m_tdata  out  NUM_CH*DATA_W  source data
m_tlast  out  NUM_CH  last beat of run, per channel
s_tvalid  in  1  sink valid from DUT
s_tlast  in  1  sink last from DUT
s_tready  out  1  sink ready to DUT
in_beat_cnt  out  NUM_CH*CNT_W  accepted source beats this run, per channel
out_beat_cnt  out  CNT_W  accepted sink beats this run
run_cnt  out  16  completed runs since reset, wrapping
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on accepted s_tlast

Behaviour:
- Reset values: all outputs 0, state IDLE, addresses 0, phase counter 0. Memory contents are NOT cleared by reset. A memory write is allowed in any state and takes effect next cycle.
- Phase counter: free-running 0..cfg_period-1, wrapping to 0. Window = (phase < cfg_on). If cfg_period==0 or cfg_on>=cfg_period, window is constantly 1.
- States:
  - IDLE: start -> RUN.
  - RUN: each channel streams. An accepted s_tvalid&s_tready&s_tlast -> RESTART if auto_restart, else IDLE.
  - RESTART: exactly 1 cycle, then RUN; run_cnt increments on entry.
  - start asserted in RUN or RESTART -> RESTART (abort and relaunch). start in the same cycle as accepted s_tlast -> RESTART regardless of auto_restart.
- Entry to RUN from IDLE and any RESTART cycle: clear rd_addr, in_beat_cnt, out_beat_cnt, and per-channel done flags.
- Source channel c, in RUN:
  - m_tvalid is registered. It rises only when window=1 and chan_done=0.
  - Once high, it holds until the handshake m_tvalid&m_tready, even if the window closes. It re-evaluates the window the cycle after the handshake.
  - m_tdata = mem_c[rd_addr_c], combinational read. It is stable while valid is held.
  - On handshake: rd_addr_c+1 (wraps DEPTH-1 -> 0), in_beat_cnt_c+1.
  - m_tlast = m_tvalid & (in_beat_cnt_c == cfg_len_c-1).
  - Handshake with m_tlast sets chan_done; m_tvalid drops next cycle and stays low until the next RESTART.
  - cfg_len_c==0: channel done immediately, never asserts m_tvalid.
- Leaving RUN (to IDLE or RESTART) forces all m_tvalid to 0 the next cycle. This is a deliberate abort; a pending beat is discarded.
- Sink:
  - s_tready = 0 in IDLE and RESTART.
  - In RUN, s_tready = window if cfg_ready_stall, else 1.
  - out_beat_cnt increments per sink handshake and does not wrap past all-ones (saturates).
  - s_tlast handshake also increments out_beat_cnt before the clear on RESTART. The counter value is visible for the done cycle only.
- done asserts in the cycle after the accepted s_tlast and lasts 1 cycle.
- Config inputs are sampled live; they must be changed only in IDLE.

Test Plan:
- Reset/idle: hold rst 5 cycles, then idle 10 cycles -> all outputs 0, busy=0, s_tready=0.
- Unthrottled single run: NUM_CH=2, cfg_len={8,4}, cfg_period=0, m_tready=1, mem_c[i]=i+16c, start pulse:
  - ch0 emits 0..7 on 8 consecutive cycles with tlast on 7; ch1 emits 16..19 with tlast on 19.
  - in_beat_cnt={8,4}.
- Throttle hold: cfg_period=8, cfg_on=2, m_tready low for 10 cycles after valid rises -> m_tvalid and m_tdata stay constant across the window close; next valid rises only at phase 0 or 1.
- Sink, auto-restart: auto_restart=1, DUT sends 5 beats with tlast on the 5th:
  - done pulses once; out_beat_cnt=5 during the done cycle; run_cnt=1.
  - One RESTART cycle with s_tready=0, then streaming resumes from address 0.
- Ready stall and stop: cfg_ready_stall=1, period=4, on=1, auto_restart=0 -> s_tready high 1 cycle in 4; after the accepted tlast, state IDLE and busy=0.
- Abort and edge cases:
  - start mid-run at beat 3 of 8 -> m_tvalid=0 next cycle; the run restarts at address 0 and in_beat_cnt clears.
  - cfg_len=0 -> channel never asserts valid.
  - cfg_len=DEPTH+2 -> address wraps and emits mem[0], mem[1] last.
